// File: rtl/inst_pkg.sv
// Shared definitions for the instruction predecode queue.
//   INST_WIDTH   instruction word width; the opcode sits in the top six bits
//   PC_WIDTH     program counter width (matches the 14-bit jump target field)
//   inst_class_t class assigned to an instruction on enqueue
package inst_pkg;

    localparam int INST_WIDTH = 32;
    localparam int PC_WIDTH   = 14;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    typedef enum logic [4:0] {
        ADD_SUB    = 5'd0,
        NEXT       = 5'd1,
        MOV        = 5'd2,
        FADD_FSUB  = 5'd3,
        FMUL       = 5'd4,
        FDIV_FSQRT = 5'd5,
        FMOV       = 5'd6,
        LW_SW      = 5'd7,
        FTOI       = 5'd8,
        ITOF       = 5'd9,
        IN         = 5'd10,
        OUT        = 5'd11,
        JR         = 5'd12,
        ACC        = 5'd13,
        JAL        = 5'd14,
        J          = 5'd15,
        B          = 5'd16,
        ILLEGAL    = 5'd17
    } inst_class_t;

endpackage

// File: rtl/inst_predecode_queue_if.sv
// Fetch/issue bundle of the predecode queue.
//   fetch side : in_valid, in_ready, in_inst, in_pc
//   issue side : out_valid, out_ready, out_inst, out_pc, out_class
//   control    : flush (drop every entry), count (occupancy)
// master = the environment (fetch + issue), slave = the queue.
interface inst_predecode_queue_if
    import inst_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [INST_WIDTH-1:0]        in_inst;
    logic [PC_WIDTH-1:0]          in_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [INST_WIDTH-1:0]        out_inst;
    logic [PC_WIDTH-1:0]          out_pc;
    inst_class_t                  out_class;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_class, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_class, count
    );

endinterface

// File: rtl/inst_predecode.sv
// Combinational opcode classifier.
//   inst       in   instruction word; only bits [31:26] matter
//   inst_class out  class of the instruction; the ordered match list lives here only
module inst_predecode
    import inst_pkg::*;
(
    input  logic [INST_WIDTH-1:0] inst,
    output inst_class_t           inst_class
);

    logic [5:0] op_s;
    logic       unused_low_s;

    assign op_s         = inst[OPCODE_MSB:OPCODE_LSB];
    assign unused_low_s = ^inst[OPCODE_LSB-1:0];

    // Ordered opcode match: earlier rows shadow later ones (JAL before J, NEXT after ADD_SUB).
    always_comb begin
        inst_class = ILLEGAL;
        if (op_s[5:3] == 3'b000 && (op_s[1] == 1'b0 || (op_s[2] == 1'b0 && op_s[0] == 1'b0))) begin
            inst_class = ADD_SUB;
        end else if (op_s == 6'b000011) begin
            inst_class = NEXT;
        end else if (op_s[5:1] == 5'b00011) begin
            inst_class = MOV;
        end else if (op_s[5:1] == 5'b00100) begin
            inst_class = FADD_FSUB;
        end else if (op_s == 6'b001010) begin
            inst_class = FMUL;
        end else if (op_s[5:3] == 3'b001 && op_s[1:0] == 2'b11) begin
            inst_class = FDIV_FSQRT;
        end else if (op_s[5:2] == 4'b0011 && op_s[1:0] != 2'b11) begin
            inst_class = FMOV;
        end else if (op_s[5:3] == 3'b010) begin
            inst_class = LW_SW;
        end else if (op_s == 6'b011000) begin
            inst_class = FTOI;
        end else if (op_s == 6'b011001) begin
            inst_class = ITOF;
        end else if (op_s[5:1] == 5'b01101) begin
            inst_class = IN;
        end else if (op_s == 6'b011100) begin
            inst_class = OUT;
        end else if (op_s == 6'b011101) begin
            inst_class = JR;
        end else if (op_s == 6'b011110) begin
            inst_class = ACC;
        end else if (op_s[5:2] == 4'b1001) begin
            inst_class = JAL;
        end else if (op_s[5:3] == 3'b100) begin
            inst_class = J;
        end else if (op_s[5] == 1'b1 && op_s[4:3] != 2'b00) begin
            inst_class = B;
        end else begin
            inst_class = ILLEGAL;
        end
    end

endmodule

// File: rtl/inst_predecode_queue.sv
// Instruction buffer between fetch and issue. Each word is classified on enqueue and
// the class is stored beside the word and its PC, so issue reads a registered class.
//   clk    in  clock
//   reset  in  synchronous, active-high
//   bus    slave side of inst_predecode_queue_if (fetch push, issue pop, flush, count)
// in_ready / out_valid are registered copies of !full / !empty. No bypass: a pushed
// entry is visible at the head one cycle later at the earliest.
module inst_predecode_queue
    import inst_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    inst_predecode_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INST_WIDTH-1:0] inst_mem_r  [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_r    [DEPTH];
    inst_class_t           class_mem_r [DEPTH];

    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  push_s;
    logic                  pop_s;
    inst_class_t           in_class_s;

    inst_predecode u_predecode (
        .inst       (bus.in_inst),
        .inst_class (in_class_s)
    );

    // Handshake qualification and next occupancy; a flush cycle cancels both transfers.
    always_comb begin
        push_s      = bus.in_valid & in_ready_r & ~bus.flush;
        pop_s       = out_valid_r & bus.out_ready & ~bus.flush;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer / count controller; ready and valid are re-derived from the next count
    // so they stay pure register outputs.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rd_ptr_r    <= PTR_W'(0);
            wr_ptr_r    <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s != CNT_W'(DEPTH));
            out_valid_r <= (count_nxt_s != CNT_W'(0));
        end
    end

    // Entry storage; written on accepted pushes only, never cleared.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            inst_mem_r[wr_ptr_r]  <= bus.in_inst;
            pc_mem_r[wr_ptr_r]    <= bus.in_pc;
            class_mem_r[wr_ptr_r] <= in_class_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_inst  = inst_mem_r[rd_ptr_r];
    assign bus.out_pc    = pc_mem_r[rd_ptr_r];
    assign bus.out_class = class_mem_r[rd_ptr_r];
    assign bus.count     = count_r;

endmodule

// File: tb/tb_inst_predecode_queue.sv
module tb_inst_predecode_queue;
    import inst_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] inst;
        logic [13:0] pc;
        inst_class_t cls;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        inst_class_t cls;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];
    inst_class_t exp_cls;
    vec_t vecs[20];

    inst_predecode_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_predecode_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [13:0] pc,
                         input inst_class_t cls, input logic rdy);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        exp_cls       = cls;
    endtask

    // Check DUT against the model, update the scoreboard, advance one clock (negedge to negedge).
    task automatic tick();
        int   sz;
        exp_t e;
        sz = sb.size();
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, sz < DEPTH});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, sz > 0});
        chk("count", 64'(bus.count), 64'(sz));
        if (reset || bus.flush) begin
            sb.delete();
        end else begin
            if (bus.out_ready && sz > 0) begin
                e = sb.pop_front();
                chk("head_inst", 64'(bus.out_inst), 64'(e.inst));
                chk("head_pc", 64'(bus.out_pc), 64'(e.pc));
                chk("head_class", 64'(bus.out_class), 64'(e.cls));
            end
            if (bus.in_valid && sz < DEPTH) begin
                e.inst = bus.in_inst;
                e.pc   = bus.in_pc;
                e.cls  = exp_cls;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs = '{
            '{6'b000000, ADD_SUB},   '{6'b000010, ADD_SUB},   '{6'b000101, ADD_SUB},
            '{6'b000011, NEXT},      '{6'b000110, MOV},       '{6'b000111, MOV},
            '{6'b001001, FADD_FSUB}, '{6'b001010, FMUL},      '{6'b001011, FDIV_FSQRT},
            '{6'b001111, FDIV_FSQRT},'{6'b001101, FMOV},      '{6'b010110, LW_SW},
            '{6'b011000, FTOI},      '{6'b011001, ITOF},      '{6'b011011, IN},
            '{6'b011100, OUT},       '{6'b011101, JR},        '{6'b011110, ACC},
            '{6'b100111, JAL},       '{6'b110101, B}
        };
        reset     = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();  // reset state

        // 1: single NEXT push, visible one cycle later
        drive(1'b1, 32'h0C000000, 14'h0010, NEXT, 1'b0);
        tick();
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b0);
        chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_class", 64'(bus.out_class), 64'(NEXT));
        chk("t1_pc", 64'(bus.out_pc), 64'h0010);
        chk("t1_count", 64'(bus.count), 64'd1);
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b1);
        tick();

        // 2: JAL, J, B, ILLEGAL in order
        drive(1'b1, 32'h90000000, 14'h0100, JAL, 1'b0);     tick();
        drive(1'b1, 32'h80000000, 14'h0104, J, 1'b0);       tick();
        drive(1'b1, 32'hA0000000, 14'h0108, B, 1'b0);       tick();
        drive(1'b1, 32'h7C000000, 14'h010C, ILLEGAL, 1'b0); tick();
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b1);
        repeat (5) tick();

        // 3: fill to full, fifth push refused, pop+push while full refuses the push
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h40000000 + 32'(i), 14'(16'h0200 + i), LW_SW, 1'b0);
            tick();
            if (i == 3) chk("t3_full_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        chk("t3_count", 64'(bus.count), 64'd4);
        drive(1'b1, 32'h60000000, 14'h02F0, FTOI, 1'b1);
        tick();
        chk("t3_after_pop", 64'(bus.count), 64'd3);
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b1);
        repeat (4) tick();

        // 4: streaming, one per cycle, pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h04000000 + 32'(i * 7), 14'(16'h0300 + i), ADD_SUB, 1'b1);
            tick();
            chk("t4_count_le1", {63'd0, bus.count <= 3'd1}, 64'd1);
        end
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b1);
        repeat (2) tick();

        // 5: flush with count=3 and a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20000000, 14'(16'h0400 + i), FADD_FSUB, 1'b0);
            tick();
        end
        drive(1'b1, 32'h7C000000, 14'h04FF, ILLEGAL, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b0);
        chk("t5_count", 64'(bus.count), 64'd0);
        chk("t5_valid", {63'd0, bus.out_valid}, 64'd0);
        drive(1'b1, 32'h18000000, 14'h0410, MOV, 1'b0);
        tick();
        chk("t5_mov_class", 64'(bus.out_class), 64'(MOV));
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b1);
        repeat (2) tick();

        // 6: reset mid-stream with count=2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hC0000000, 14'(16'h0500 + i), B, 1'b0);
            tick();
        end
        drive(1'b1, 32'hC0000000, 14'h0502, B, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b0);
        chk("t6_count", 64'(bus.count), 64'd0);
        chk("t6_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("t6_valid", {63'd0, bus.out_valid}, 64'd0);
        tick();

        // classification table, streamed through the queue
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {vecs[i].op, 26'h1234567}, 14'(16'h0600 + i), vecs[i].cls, 1'b1);
            tick();
        end
        drive(1'b0, 32'd0, 14'd0, ILLEGAL, 1'b1);
        for (int k = 0; k < 8 && sb.size() > 0; k++) tick();
        tick();
        chk("final_empty", {63'd0, bus.out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
